// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter sharing a single-port synchronous memory (IDLE/ISSUE/WAIT).
// Define MEM_ARB_RR_EN for round-robin tie breaking; default is fixed priority to port 0.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_in
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic cur_q, cur_d, wr_q, wr_d, sel;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d, mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d, mem_data_q, mem_data_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
  assign sel = (req0 && req1) ? ~last_q : ~req0;
`else
  assign sel = ~req0;
`endif
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    wr_d       = wr_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    mem_we_d   = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
`ifdef MEM_ARB_RR_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: if (req0 || req1) begin
        state_d    = ISSUE;
        cur_d      = sel;
        wr_d       = sel ? we1 : we0;
        mem_we_d   = sel ? we1 : we0;
        mem_addr_d = sel ? addr1 : addr0;
        mem_data_d = sel ? wdata1 : wdata0;
        gnt0_d     = ~sel;
        gnt1_d     = sel;
`ifdef MEM_ARB_RR_EN
        last_d     = sel;
`endif
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d   = IDLE;
        rvalid0_d = ~wr_q & ~cur_q;
        rvalid1_d = ~wr_q & cur_q;
        rdata0_d  = (~wr_q & ~cur_q) ? mem_in : rdata0_q;
        rdata1_d  = (~wr_q & cur_q) ? mem_in : rdata1_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= 1'b0;
      wr_q       <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      wr_q       <= wr_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      mem_we_q   <= mem_we_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
`ifdef MEM_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end
  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven bench for mem_arbiter with a behavioural synchronous memory.
module tb_mem_arbiter;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [5:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [15:0] rdata0, rdata1, mem_data, mem_in;
  logic [5:0] mem_addr;
  logic [15:0] mem [64];
  int checks = 0, errors = 0;
  mem_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_in(mem_in)
  );
  always #5 clk = ~clk;
  // Memory contents after reset are 16'hC000 | addr.
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 64; i++) mem[i] <= 16'hC000 | 16'(i);
    else if (mem_we) mem[mem_addr] <= mem_data;
    mem_in <= mem[mem_addr];
  end
  typedef struct {
    logic r0; logic w0; logic [5:0] a0; logic [15:0] d0;
    logic r1; logic w1; logic [5:0] a1; logic [15:0] d1;
    logic g; logic [15:0] rd;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input vec_t v);
    logic w;
    logic [5:0] a;
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    w = v.g ? v.w1 : v.w0;
    a = v.g ? v.a1 : v.a0;
    step();
    chk("gnt0_issue", gnt0, !v.g);
    chk("gnt1_issue", gnt1, v.g);
    chk("mem_we_issue", mem_we, w);
    chk("mem_addr_issue", mem_addr, a);
    if (w) chk("mem_data_issue", mem_data, v.g ? v.d1 : v.d0);
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk("gnt_wait", {gnt0, gnt1}, 2'b00);
    chk("mem_we_wait", mem_we, 1'b0);
    chk("rvalid_wait", {rvalid0, rvalid1}, 2'b00);
    step();
    chk("rvalid_done", {rvalid0, rvalid1}, w ? 2'b00 : (v.g ? 2'b01 : 2'b10));
    chk("mem_addr_hold", mem_addr, a);
    if (!w) chk("rdata_done", v.g ? rdata1 : rdata0, v.rd);
  endtask
  initial begin
    logic prev;
    tbl[0] = '{1'b0, 1'b0, 6'd0, 16'd0, 1'b1, 1'b0, 6'd5, 16'd0, 1'b1, 16'hC005};
    tbl[1] = '{1'b1, 1'b1, 6'd10, 16'hBEEF, 1'b0, 1'b0, 6'd0, 16'd0, 1'b0, 16'd0};
    tbl[2] = '{1'b1, 1'b0, 6'd63, 16'd0, 1'b0, 1'b0, 6'd0, 16'd0, 1'b0, 16'hC03F};
    tbl[3] = '{1'b0, 1'b0, 6'd0, 16'd0, 1'b1, 1'b0, 6'd10, 16'd0, 1'b1, 16'hBEEF};
    for (int i = 4; i < 8; i++)
      tbl[i] = '{1'b1, 1'b0, 6'd1, 16'd0, 1'b1, 1'b0, 6'd2, 16'd0,
                 RR && i[0], (RR && i[0]) ? 16'hC002 : 16'hC001};
    step();
    step();
    chk("rst_gnt", {gnt0, gnt1}, 2'b00);
    chk("rst_rvalid", {rvalid0, rvalid1}, 2'b00);
    chk("rst_rdata0", rdata0, 16'd0);
    chk("rst_rdata1", rdata1, 16'd0);
    chk("rst_mem", {mem_we, mem_addr, mem_data}, 23'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) txn(tbl[i]);
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd3;
    prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("held_gnt0", gnt0, (i % 3) == 0);
      chk("held_gnt1", gnt1, 1'b0);
      chk("held_consec", prev & gnt0, 1'b0);
      prev = gnt0;
    end
    req0 = 1'b0;
    step();
    step();
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd7;
    step();
    chk("rw_gnt1", gnt1, 1'b1);
    req1 = 1'b0;
    step();
    chk("rw_wait_addr", mem_addr, 6'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rw_rvalid1", rvalid1, 1'b0);
    chk("rw_rdata1", rdata1, 16'd0);
    chk("rw_rdata0", rdata0, 16'd0);
    chk("rw_gnt", {gnt0, gnt1}, 2'b00);
    chk("rw_mem", {mem_we, mem_addr, mem_data}, 23'd0);
    txn('{1'b0, 1'b0, 6'd0, 16'd0, 1'b1, 1'b0, 6'd7, 16'd0, 1'b1, 16'hC007});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
